fifo_param: RTL



---
 rtl/fifo_param.sv | 114 +++++++++++
 1 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with exact occupancy count, almost-full/empty
// thresholds and overflow/underflow pulses. Define FIFO_FWFT_EN for first-word fall-through.
module fifo_param #(
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned AWIDTH   = 4,
  parameter int unsigned AF_LEVEL = 2**AWIDTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              f_full,
  output logic              f_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned     DEPTH   = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_ok, wr_ok;

  assign f_empty      = (count_q == '0);
  assign f_full       = (count_q == DEPTH_C);
  assign almost_full  = (32'(count_q) >= AF_LEVEL);
  assign almost_empty = (32'(count_q) <= AE_LEVEL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still accepts a write when the same cycle frees a slot;
  // an empty FIFO never serves a read, even alongside a write.
  always_comb begin
    rd_ok       = rd_en && !f_empty;
    wr_ok       = wr_en && (!f_full || rd_en);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en && f_full && !rd_en;
    underflow_d = rd_en && f_empty;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out   = f_empty ? '0 : mem_q[rd_ptr_q];
  assign data_valid = !f_empty;
`else
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (rd_ok) begin
      data_out_d   = mem_q[rd_ptr_q];
      data_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

endmodule
